// File: rtl/rtc_spi_bridge.sv
// CPU-to-RTC bridge: bus-mapped ctrl/data registers driving an SPI mode-0 master toward the MCU.
// Build option RTC_MCU_ACK_EN: when defined, wait for MCUReadyFallingEdge after the command byte.
module rtc_spi_bridge #(
    parameter logic [7:0] DUMMY_BYTE = 8'hFF
) (
    input  logic       SClk,
    input  logic       nReset,
    input  logic       nWE,
    input  logic       nOE,
    input  logic [7:0] WriteData,
    input  logic       SelRTCCtrl,
    input  logic       SelRTCData,
    input  logic       MCUReadyFallingEdge,
    output logic [7:0] RTCCtrl,
    output logic [7:0] RTCData,
    input  logic       SPIDi,
    output logic       SPIDo,
    output logic       SPIClk,
    output logic       nMCUSel,
    output logic [2:0] fsm_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CMD      = 3'd1,
        S_WAIT_ACK = 3'd2,
        S_XFER     = 3'd3,
        S_WAIT_CPU = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t     state, next_state;
    logic [3:0] cmd;
    logic       busy, ready;
    logic [7:0] data_reg;
    logic [2:0] remain;

    logic       wr_done, oe_q;
    logic       wr_stb, ctrl_wr, data_wr, data_rd;

    logic       spi_start, spi_done, spi_active;
    logic [7:0] spi_tx, tx_sh, rx_sh;
    logic [2:0] bit_cnt;
    logic       go_data;

    function automatic logic [2:0] xfer_len(input logic [2:0] sel);
        case (sel)
            3'd1:    xfer_len = 3'd1;
            3'd2:    xfer_len = 3'd7;
            3'd3:    xfer_len = 3'd3;
            3'd4:    xfer_len = 3'd2;
            default: xfer_len = 3'd0;
        endcase
    endfunction

    // A write acts once per nWE low pulse; a read acts on the nOE rising edge.
    always_ff @(posedge SClk or negedge nReset) begin
        if (!nReset) begin
            wr_done <= 1'b0;
            oe_q    <= 1'b1;
        end else begin
            oe_q <= nOE;
            if (nWE)
                wr_done <= 1'b0;
            else if (SelRTCCtrl || SelRTCData)
                wr_done <= 1'b1;
        end
    end

    assign wr_stb  = !nWE && (SelRTCCtrl || SelRTCData) && !wr_done;
    assign ctrl_wr = wr_stb && SelRTCCtrl;
    assign data_wr = wr_stb && SelRTCData;
    assign data_rd = nOE && !oe_q && SelRTCData;

    // CPU handshake: ready=1 means RTCData holds a fresh byte (read) or the last byte
    // left (write); the CPU consumes it with one RTCData access, which drops ready and
    // launches the next byte. No byte moves while ready is high in WAIT_CPU.
    always_ff @(posedge SClk or negedge nReset) begin
        if (!nReset)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        spi_start  = 1'b0;
        spi_tx     = DUMMY_BYTE;
        go_data    = 1'b0;
        case (state)
            S_IDLE: begin
                if (ctrl_wr && WriteData[4]) begin
                    next_state = S_CMD;
                    spi_start  = 1'b1;
                    spi_tx     = {4'hF, WriteData[3:0]};
                end
            end
            S_CMD: begin
                if (spi_done) begin
`ifdef RTC_MCU_ACK_EN
                    next_state = S_WAIT_ACK;
`else
                    go_data = 1'b1;
`endif
                end
            end
            S_WAIT_ACK: begin
                if (MCUReadyFallingEdge)
                    go_data = 1'b1;
            end
            S_XFER: begin
                if (spi_done)
                    next_state = (remain == 3'd1) ? S_DONE : S_WAIT_CPU;
            end
            S_WAIT_CPU: begin
                if (!cmd[0] && data_wr) begin
                    next_state = S_XFER;
                    spi_start  = 1'b1;
                    spi_tx     = WriteData;
                end else if (cmd[0] && data_rd) begin
                    next_state = S_XFER;
                    spi_start  = 1'b1;
                    spi_tx     = DUMMY_BYTE;
                end
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
        if (go_data) begin
            if (remain == 3'd0) begin
                next_state = S_DONE;
            end else begin
                next_state = S_XFER;
                spi_start  = 1'b1;
                spi_tx     = cmd[0] ? DUMMY_BYTE : data_reg;
            end
        end
    end

    always_ff @(posedge SClk or negedge nReset) begin
        if (!nReset) begin
            cmd      <= 4'h0;
            busy     <= 1'b0;
            ready    <= 1'b0;
            data_reg <= 8'h00;
            remain   <= 3'd0;
            nMCUSel  <= 1'b1;
        end else begin
            if (state == S_IDLE && spi_start) begin
                cmd    <= WriteData[3:0];
                ready  <= 1'b0;
                remain <= xfer_len(WriteData[3:1]);
            end
            if (state == S_IDLE && data_wr)
                data_reg <= WriteData;
            // The command byte's MISO data is never loaded; only data-phase bytes are.
            if (state == S_XFER && spi_done) begin
                ready  <= 1'b1;
                remain <= remain - 3'd1;
                if (cmd[0])
                    data_reg <= rx_sh;
            end
            if (state == S_WAIT_CPU && spi_start) begin
                ready <= 1'b0;
                if (!cmd[0])
                    data_reg <= WriteData;
            end
            busy    <= !(next_state == S_IDLE || next_state == S_DONE);
            nMCUSel <=  (next_state == S_IDLE || next_state == S_DONE);
        end
    end

    // SPI mode 0 master: SPIClk doubles as the half-bit phase; MISO sampled as SPIClk rises.
    always_ff @(posedge SClk or negedge nReset) begin
        if (!nReset) begin
            SPIClk     <= 1'b0;
            SPIDo      <= 1'b1;
            tx_sh      <= 8'h00;
            rx_sh      <= 8'h00;
            bit_cnt    <= 3'd0;
            spi_active <= 1'b0;
            spi_done   <= 1'b0;
        end else begin
            spi_done <= 1'b0;
            if (spi_start) begin
                SPIDo      <= spi_tx[7];
                tx_sh      <= {spi_tx[6:0], 1'b0};
                bit_cnt    <= 3'd0;
                SPIClk     <= 1'b0;
                spi_active <= 1'b1;
            end else if (spi_active) begin
                if (!SPIClk) begin
                    SPIClk <= 1'b1;
                    rx_sh  <= {rx_sh[6:0], SPIDi};
                end else begin
                    SPIClk <= 1'b0;
                    if (bit_cnt == 3'd7) begin
                        spi_active <= 1'b0;
                        spi_done   <= 1'b1;
                        SPIDo      <= 1'b1;
                    end else begin
                        SPIDo   <= tx_sh[7];
                        tx_sh   <= {tx_sh[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end
            end
        end
    end

    assign RTCCtrl   = {ready, 2'b00, busy, cmd};
    assign RTCData   = data_reg;
    assign fsm_state = state;

endmodule

// File: tb/tb_rtc_spi_bridge.sv
// Directed bench for rtc_spi_bridge: CPU bus driver, SPI slave model of the MCU,
// MOSI/read-data scoreboards built from queues filled as stimulus is issued.
module tb_rtc_spi_bridge;

    logic       SClk = 1'b0;
    logic       nReset = 1'b0;
    logic       nWE = 1'b1;
    logic       nOE = 1'b1;
    logic [7:0] WriteData = 8'h00;
    logic       SelRTCCtrl = 1'b0;
    logic       SelRTCData = 1'b0;
    logic       MCUReadyFallingEdge = 1'b0;
    logic       SPIDi = 1'b0;
    logic [7:0] RTCCtrl, RTCData;
    logic       SPIDo, SPIClk, nMCUSel;
    logic [2:0] fsm_state;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0] exp_q[$];
    logic [7:0] miso_q[$];
    logic [7:0] rd_exp_q[$];

    int         slave_bytes = 0;
    int         slave_bits = 0;
    logic [7:0] mosi_sh = 8'h00;
    logic [7:0] miso_sh = 8'h00;

    rtc_spi_bridge #(.DUMMY_BYTE(8'hFF)) dut (
        .SClk                (SClk),
        .nReset              (nReset),
        .nWE                 (nWE),
        .nOE                 (nOE),
        .WriteData           (WriteData),
        .SelRTCCtrl          (SelRTCCtrl),
        .SelRTCData          (SelRTCData),
        .MCUReadyFallingEdge (MCUReadyFallingEdge),
        .RTCCtrl             (RTCCtrl),
        .RTCData             (RTCData),
        .SPIDi               (SPIDi),
        .SPIDo               (SPIDo),
        .SPIClk              (SPIClk),
        .nMCUSel             (nMCUSel),
        .fsm_state           (fsm_state)
    );

    // Clock / watchdog
    always #5 SClk = ~SClk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // MCU side: SPI mode 0 slave; MISO changes on SPIClk falling edges.
    always @(negedge nMCUSel) begin
        slave_bits = 0;
        miso_sh    = 8'hC3;
        SPIDi      = miso_sh[7];
    end

    always @(posedge nMCUSel) slave_bits = 0;

    always @(posedge SPIClk) begin
        if (nMCUSel === 1'b0) begin
            mosi_sh = {mosi_sh[6:0], SPIDo};
            slave_bits++;
            if (slave_bits == 8) begin
                slave_bytes++;
                if (exp_q.size() == 0)
                    check("mosi_unexpected_byte", 32'(exp_q.size()), 32'd1);
                else
                    check("mosi_byte", 32'(mosi_sh), 32'(exp_q.pop_front()));
            end
        end
    end

    always @(negedge SPIClk) begin
        if (nMCUSel === 1'b0) begin
            if (slave_bits == 8) begin
                slave_bits = 0;
                miso_sh = (miso_q.size() > 0) ? miso_q.pop_front() : 8'h00;
            end
            SPIDi = miso_sh[7 - slave_bits];
        end
    end

    // CPU bus drivers
    task automatic bus_write(input logic to_ctrl, input logic [7:0] d);
        @(negedge SClk);
        SelRTCCtrl = to_ctrl;
        SelRTCData = !to_ctrl;
        WriteData  = d;
        nWE        = 1'b0;
        repeat (2) @(negedge SClk);
        nWE = 1'b1;
        @(negedge SClk);
        SelRTCCtrl = 1'b0;
        SelRTCData = 1'b0;
    endtask

    task automatic bus_read(output logic [7:0] d);
        @(negedge SClk);
        SelRTCData = 1'b1;
        nOE        = 1'b0;
        @(negedge SClk);
        d   = RTCData;
        nOE = 1'b1;
        @(negedge SClk);
        SelRTCData = 1'b0;
    endtask

    task automatic pulse_ack();
        @(negedge SClk);
        MCUReadyFallingEdge = 1'b1;
        repeat (3) @(negedge SClk);
        MCUReadyFallingEdge = 1'b0;
    endtask

    task automatic wait_bytes(input int target, input string tag);
        int n = 0;
        while (slave_bytes < target && n < 1000) begin
            @(negedge SClk);
            n++;
        end
        check({tag, "_byte_seen"}, 32'(slave_bytes >= target), 32'd1);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (RTCCtrl[7] !== 1'b1 && n < 1000) begin
            @(negedge SClk);
            n++;
        end
        check({tag, "_ready"}, 32'(RTCCtrl[7]), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (RTCCtrl[4] !== 1'b0 && n < 1000) begin
            @(negedge SClk);
            n++;
        end
        check({tag, "_busy_clear"}, 32'(RTCCtrl[4]), 32'd0);
        check({tag, "_sel_high"}, 32'(nMCUSel), 32'd1);
    endtask

    initial begin
        logic [7:0] rd;
        logic [7:0] rd_vals[7];
        int base;

        rd_vals = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h22};

        // Reset values
        repeat (3) @(negedge SClk);
        check("rst_ctrl", 32'(RTCCtrl), 32'h00);
        check("rst_data", 32'(RTCData), 32'h00);
        check("rst_sel", 32'(nMCUSel), 32'd1);
        check("rst_spiclk", 32'(SPIClk), 32'd0);
        check("rst_spido", 32'(SPIDo), 32'd1);
        nReset = 1'b1;
        @(negedge SClk);

        // Zero-length command
        exp_q.push_back(8'hF0);
        base = slave_bytes;
        bus_write(1'b1, 8'h10);
        check("t_len0_ctrl_busy", 32'(RTCCtrl), 32'h10);
        check("t_len0_sel_low", 32'(nMCUSel), 32'd0);
        wait_bytes(base + 1, "t_len0_cmd");
        pulse_ack();
        wait_idle("t_len0");
        check("t_len0_ctrl_done", 32'(RTCCtrl), 32'h00);

        // One-byte read; command-phase MISO (C3) must be discarded
        exp_q.push_back(8'hF3);
        exp_q.push_back(8'hFF);
        miso_q.push_back(8'hEE);
        base = slave_bytes;
        bus_write(1'b1, 8'h13);
        check("t_rd1_ctrl_busy", 32'(RTCCtrl), 32'h13);
        wait_bytes(base + 1, "t_rd1_cmd");
        pulse_ack();
        wait_idle("t_rd1");
        check("t_rd1_data", 32'(RTCData), 32'hEE);
        check("t_rd1_ctrl_done", 32'(RTCCtrl), 32'h83);

        // Two-byte write, with a ctrl write while busy that must be ignored
        bus_write(1'b0, 8'h22);
        check("t_wr_idle_load", 32'(RTCData), 32'h22);
        exp_q.push_back(8'hF8);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        base = slave_bytes;
        bus_write(1'b1, 8'h18);
        check("t_wr_ctrl_busy", 32'(RTCCtrl), 32'h18);
        wait_bytes(base + 1, "t_wr_cmd");
        pulse_ack();
        wait_ready("t_wr_b0");
        check("t_wr_ctrl_ready", 32'(RTCCtrl), 32'h98);
        bus_write(1'b1, 8'h11);
        check("t_wr_ctrl_ignored", 32'(RTCCtrl), 32'h98);
        bus_write(1'b0, 8'h33);
        check("t_wr_ready_cleared", 32'(RTCCtrl), 32'h18);
        wait_idle("t_wr");
        check("t_wr_ctrl_done", 32'(RTCCtrl), 32'h88);
        check("t_wr_data", 32'(RTCData), 32'h33);

        // Seven-byte read
        exp_q.push_back(8'hF5);
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(8'hFF);
            miso_q.push_back(rd_vals[i]);
            rd_exp_q.push_back(rd_vals[i]);
        end
        base = slave_bytes;
        bus_write(1'b1, 8'h15);
        wait_bytes(base + 1, "t_rd7_cmd");
        pulse_ack();
        for (int i = 0; i < 7; i++) begin
            wait_ready("t_rd7");
            bus_read(rd);
            check("t_rd7_data", 32'(rd), 32'(rd_exp_q.pop_front()));
        end
        wait_idle("t_rd7");
        check("t_rd7_ctrl_done", 32'(RTCCtrl), 32'h85);

        // Reset in the middle of a data byte
        exp_q.push_back(8'hF5);
        base = slave_bytes;
        bus_write(1'b1, 8'h15);
        wait_bytes(base + 1, "t_rst_cmd");
        pulse_ack();
        repeat (6) @(negedge SClk);
        nReset = 1'b0;
        #1;
        check("t_rst_ctrl", 32'(RTCCtrl), 32'h00);
        check("t_rst_sel", 32'(nMCUSel), 32'd1);
        check("t_rst_spiclk", 32'(SPIClk), 32'd0);
        check("t_rst_spido", 32'(SPIDo), 32'd1);
        check("t_rst_data", 32'(RTCData), 32'h00);
        check("t_rst_mosi_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        miso_q.delete();
        @(negedge SClk);
        nReset = 1'b1;
        @(negedge SClk);

        // Normal command after reset
        exp_q.push_back(8'hF3);
        exp_q.push_back(8'hFF);
        miso_q.push_back(8'h5A);
        base = slave_bytes;
        bus_write(1'b1, 8'h13);
        wait_bytes(base + 1, "t_post_cmd");
        pulse_ack();
        wait_idle("t_post");
        check("t_post_data", 32'(RTCData), 32'h5A);
        check("t_post_ctrl", 32'(RTCCtrl), 32'h83);

        repeat (4) @(negedge SClk);
        check("mosi_pending", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rtc_spi_bridge.md
RTC_SPI_BRIDGE -- requirements
Module: rtc_spi_bridge

Interface
REQ-001 Parameter DUMMY_BYTE, default 8'hFF: byte shifted out while reading RTC data.
REQ-002 SClk  in  1  system clock; all state on rising edge.
REQ-003 nReset  in  1  asynchronous, active-low reset.
REQ-004 nWE  in  1  bus write strobe, active low; nOE  in  1  bus read strobe, active low.
REQ-005 WriteData  in  8  bus write data; SelRTCCtrl, SelRTCData  in  1  register selects.
REQ-006 MCUReadyFallingEdge  in  1  one-or-more-cycle pulse: MCU acknowledged command byte.
REQ-007 RTCCtrl  out  8  {ready, 2'b00, busy, cmd[3:0]}; RTCData  out  8  data register.
REQ-008 SPIDi  in  1  MISO; SPIDo  out  1  MOSI; SPIClk  out  1  SPI clock (idle low); nMCUSel  out  1  MCU chip select, active low.

Function
REQ-009 Bus write = first SClk cycle with nWE low and a select high; one action per nWE low pulse; read side effect on nOE rising edge while SelRTCData high.
REQ-010 Write to ctrl with WriteData[4]=1 while idle: latch cmd=WriteData[3:0], set busy, clear ready, drive nMCUSel low, send command byte {4'hF, cmd}; ctrl write while busy ignored.
REQ-011 Length by cmd[3:1]: 0->0, 1->1, 2->7, 3->3, 4->2, 5..7->0 bytes; cmd[0]=1 read, 0 write.
REQ-012 SPI mode 0, MSB first, one bit per two SClk cycles; SPIDo/SPIClk registered; received bits sampled on SPIClk rising edge.
REQ-013 States: IDLE, CMD, WAIT_ACK, XFER, WAIT_CPU, DONE.
REQ-014 After command byte: WAIT_ACK until MCUReadyFallingEdge; length 0 -> DONE.
REQ-015 Write: after ack, transmit current RTCData; after each byte set ready; CPU write to RTCData clears ready and sends next byte; after last byte -> DONE.
REQ-016 Read: each byte transmits DUMMY_BYTE, received byte loads RTCData, ready set; CPU read of RTCData clears ready and starts next byte if any remain; after last byte -> DONE without waiting for read.
REQ-017 DONE: nMCUSel high, busy cleared, one cycle, -> IDLE; ready keeps value; RTCData holds last byte.
REQ-018 RTCData write while idle loads register directly.
REQ-019 Command byte received data discarded; nMCUSel stays low for whole transaction.

Reset
REQ-020 nReset low: state IDLE, RTCCtrl=8'h00, RTCData=8'h00, nMCUSel=1, SPIClk=0, SPIDo=1; mid-transaction reset aborts immediately.

Configuration
REQ-021 Macro RTC_MCU_ACK_EN defined: WAIT_ACK as REQ-014; undefined: WAIT_ACK skipped, data phase starts immediately after command byte, MCUReadyFallingEdge ignored.

Verification
REQ-022 Ctrl write 8'h10, ack -> MCU receives 8'hF0, busy clears, nMCUSel high.
REQ-023 Ctrl 8'h13, MCU returns 8'hEE -> MCU receives F3 then FF; busy clears; RTCData=8'hEE.
REQ-024 RTCData=8'h22, ctrl 8'h18, ack -> MCU receives F8, ready set, 22; write 8'h33 -> receives 33, busy clears.
REQ-025 Ctrl 8'h15, MCU returns AA,BB,CC,DD,EE,FF,22 -> F5 then seven FF; each ready read yields AA..22 in order.
REQ-026 Reset asserted during XFER -> RTCCtrl=00, nMCUSel=1 immediately; next command completes normally.
